// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and FSM encoding for the instruction-fetch unit
package if_pkg;
    localparam int          IF_PC_WIDTH = 10;
    localparam logic [31:0] IF_NOP      = 32'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - IM request/response, branch, hazard and IF/ID-facing signals
interface inst_fetch_unit_if #(
    parameter int PC_WIDTH = if_pkg::IF_PC_WIDTH
);
    logic                oIM_req;
    logic [PC_WIDTH-1:0] oIM_addr;
    logic                iIM_ack;
    logic [31:0]         iIM_data;
    logic                iBRANCH_taken;
    logic [PC_WIDTH-1:0] iBRANCH_target;
    logic                do_hazard;
    logic [31:0]         oIF_instruction;
    logic [PC_WIDTH-1:0] oIF_current_pc;
    logic                oIF_valid;

    modport master (
        output oIM_req, oIM_addr, oIF_instruction, oIF_current_pc, oIF_valid,
        input  iIM_ack, iIM_data, iBRANCH_taken, iBRANCH_target, do_hazard
    );

    modport slave (
        input  oIM_req, oIM_addr, oIF_instruction, oIF_current_pc, oIF_valid,
        output iIM_ack, iIM_data, iBRANCH_taken, iBRANCH_target, do_hazard
    );
endinterface

// File: rtl/if_prefetch_fifo.sv
// rtl/if_prefetch_fifo.sv - prefetch FIFO of {pc, instr} with flush
// Caller guarantees no push when full and no pop when empty; flush beats push and pop.
module if_prefetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch FSM, PC register, credit/discard control, IF/ID output mux
// IF_PERF_CNT_EN adds saturating push/branch counters.
module inst_fetch_unit
    import if_pkg::*;
#(
    parameter int                  PC_WIDTH   = IF_PC_WIDTH,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic clock,
    input  logic reset_n,
    inst_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0] oPERF_fetch_cnt,
    output logic [15:0] oPERF_flush_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                discard_q, discard_d;

    logic [CW-1:0]          fifo_count, count_after;
    logic [PC_WIDTH+31:0]   fifo_head;
    logic [PC_WIDTH-1:0]    head_pc;
    logic [31:0]            head_instr;
    logic                   fifo_valid, issue, push, pop, branch;

    assign branch      = bus.iBRANCH_taken;
    assign fifo_valid  = (fifo_count != '0);
    assign issue       = (state_q == ST_REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign push        = (state_q == ST_WAIT) && bus.iIM_ack && !discard_q && !branch;
    assign pop         = fifo_valid && !bus.do_hazard && !branch;
    assign count_after = fifo_count + CW'(1) - CW'(pop);
    assign head_pc     = fifo_head[32 +: PC_WIDTH];
    assign head_instr  = fifo_head[31:0];

    if_prefetch_fifo #(
        .WIDTH (PC_WIDTH + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .flush     (branch),
        .push      (push),
        .push_data ({fetch_pc_q, bus.iIM_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  state_d = issue ? ST_WAIT : ST_FULL;
            ST_WAIT: begin
                if (bus.iIM_ack) begin
                    discard_d = 1'b0;
                    if (discard_q) begin
                        state_d = ST_REQ;
                    end else begin
                        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
                        state_d    = (count_after < CW'(FIFO_DEPTH)) ? ST_REQ : ST_FULL;
                    end
                end
            end
            ST_FULL: if (pop) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
        // A request issued this cycle or still awaiting its ack must have its data dropped.
        if (branch) begin
            fetch_pc_d = bus.iBRANCH_target;
            if (issue || (state_q == ST_WAIT && !bus.iIM_ack)) begin
                discard_d = 1'b1;
                state_d   = ST_WAIT;
            end else begin
                discard_d = 1'b0;
                state_d   = ST_REQ;
            end
        end
    end

    always_comb begin
        bus.oIM_req         = issue;
        bus.oIM_addr        = fetch_pc_q;
        bus.oIF_valid       = fifo_valid;
        bus.oIF_instruction = fifo_valid ? head_instr : IF_NOP;
        bus.oIF_current_pc  = fifo_valid ? head_pc : '0;
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (push && fetch_cnt_q != 16'hFFFF)   fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (branch && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign oPERF_fetch_cnt = fetch_cnt_q;
    assign oPERF_flush_cnt = flush_cnt_q;
`endif
endmodule
